// File: rtl/connect4_line_scanner.sv
// Walks the four lines through a newly placed Connect4 piece, one board read at a time.
// Optional early exit on the first winning line: define CONNECT4_EARLY_EXIT_EN.
//
// state | meaning
// IDLE  | waiting for start
// STEP  | compute next target cell, issue read if in bounds
// WAIT  | evaluate returned cell
// DONE  | one-cycle result pulse
module connect4_line_scanner #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] row,
    input  logic [2:0] col,
    input  logic [1:0] player,
    output logic       rd_en,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       win,
    output logic [1:0] win_dir
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0]        ROWS_U = 4'(ROWS);
    localparam logic [3:0]        COLS_U = 4'(COLS);
    localparam logic signed [3:0] ROWS_S = 4'(ROWS);
    localparam logic signed [3:0] COLS_S = 4'(COLS);

    state_t     state, state_nxt;
    logic [2:0] cell_row, cell_row_nxt;
    logic [2:0] cell_col, cell_col_nxt;
    logic [1:0] colour, colour_nxt;
    logic [1:0] dir, dir_nxt;
    logic       side_neg, side_neg_nxt;
    logic [1:0] k, k_nxt;
    logic [2:0] count, count_nxt;
    logic       win_nxt;
    logic [1:0] win_dir_nxt;

    logic signed [3:0] k_s, off_r, off_c, tgt_r, tgt_c;
    logic              in_bounds;
    logic              valid_req;
    logic              side_end;
    logic              dir_win;
    logic              last_dir;
    logic [2:0]        cnt_eff;

    // Coordinates can only wrap past +7 into negative values, which the bounds check rejects.
    always_comb begin
        k_s   = $signed({2'b00, k});
        off_r = (dir == 2'd0) ? 4'sd0 : k_s;
        off_c = (dir == 2'd1) ? 4'sd0 : ((dir == 2'd3) ? -k_s : k_s);
        if (side_neg) begin
            off_r = -off_r;
            off_c = -off_c;
        end
        tgt_r     = $signed({1'b0, cell_row}) + off_r;
        tgt_c     = $signed({1'b0, cell_col}) + off_c;
        in_bounds = (tgt_r >= 4'sd0) && (tgt_r < ROWS_S) &&
                    (tgt_c >= 4'sd0) && (tgt_c < COLS_S);
    end

    assign valid_req = ((player == 2'b01) || (player == 2'b10)) &&
                       ({1'b0, row} < ROWS_U) && ({1'b0, col} < COLS_U);

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_comb begin
        state_nxt    = state;
        cell_row_nxt = cell_row;
        cell_col_nxt = cell_col;
        colour_nxt   = colour;
        dir_nxt      = dir;
        side_neg_nxt = side_neg;
        k_nxt        = k;
        count_nxt    = count;
        win_nxt      = win;
        win_dir_nxt  = win_dir;
        rd_en        = 1'b0;
        rd_row       = 3'd0;
        rd_col       = 3'd0;
        side_end     = 1'b0;
        cnt_eff      = count;
        dir_win      = 1'b0;
        last_dir     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    cell_row_nxt = row;
                    cell_col_nxt = col;
                    colour_nxt   = player;
                    win_nxt      = 1'b0;
                    win_dir_nxt  = 2'd0;
                    dir_nxt      = 2'd0;
                    side_neg_nxt = 1'b0;
                    k_nxt        = 2'd1;
                    count_nxt    = 3'd1;
                    state_nxt    = valid_req ? S_STEP : S_DONE;
                end
            end
            S_STEP: begin
                if (in_bounds) begin
                    rd_en     = 1'b1;
                    rd_row    = tgt_r[2:0];
                    rd_col    = tgt_c[2:0];
                    state_nxt = S_WAIT;
                end else begin
                    side_end = 1'b1;
                end
            end
            S_WAIT: begin
                if (rd_data == colour) begin
                    count_nxt = count + 3'd1;
                    cnt_eff   = count + 3'd1;
                    if (k != 2'd3) begin
                        k_nxt     = k + 2'd1;
                        state_nxt = S_STEP;
                    end else begin
                        side_end = 1'b1;
                    end
                end else begin
                    side_end = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (side_end) begin
            if (!side_neg) begin
                side_neg_nxt = 1'b1;
                k_nxt        = 2'd1;
                state_nxt    = S_STEP;
            end else begin
                dir_win = (cnt_eff >= 3'd4);
                if (dir_win && !win) begin
                    win_nxt     = 1'b1;
                    win_dir_nxt = dir;
                end
`ifdef CONNECT4_EARLY_EXIT_EN
                last_dir = (dir == 2'd3) || dir_win;
`else
                last_dir = (dir == 2'd3);
`endif
                if (last_dir) begin
                    state_nxt = S_DONE;
                end else begin
                    dir_nxt      = dir + 2'd1;
                    side_neg_nxt = 1'b0;
                    k_nxt        = 2'd1;
                    count_nxt    = 3'd1;
                    state_nxt    = S_STEP;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cell_row <= 3'd0;
            cell_col <= 3'd0;
            colour   <= 2'd0;
            dir      <= 2'd0;
            side_neg <= 1'b0;
            k        <= 2'd1;
            count    <= 3'd1;
            win      <= 1'b0;
            win_dir  <= 2'd0;
        end else begin
            state    <= state_nxt;
            cell_row <= cell_row_nxt;
            cell_col <= cell_col_nxt;
            colour   <= colour_nxt;
            dir      <= dir_nxt;
            side_neg <= side_neg_nxt;
            k        <= k_nxt;
            count    <= count_nxt;
            win      <= win_nxt;
            win_dir  <= win_dir_nxt;
        end
    end

endmodule
